// File: rtl/updown_counter_multimode_if.sv
// Control/status bundle for updown_counter_multimode.
// The master drives the counter controls; the slave (the counter) returns its registered status.
interface updown_counter_multimode_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
);
   logic              enable;
   logic              up_down;
   logic              load;
   logic [WIDTH-1:0]  load_value;
   logic [STEP_W-1:0] step;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  count;
   logic              tc;
   logic              dir;
   logic              done;

   modport master (
      output enable, up_down, load, load_value, step, mode,
      input  count, tc, dir, done
   );

   modport slave (
      input  enable, up_down, load, load_value, step, mode,
      output count, tc, dir, done
   );
endinterface

// File: rtl/updown_counter_multimode.sv
// Up/down counter over [0, MAX_COUNT] with wrap, saturate, one-shot and ping-pong modes,
// synchronous load and a registered one-cycle terminal-count pulse.
// Optional macro COUNTER_PRESCALE_EN adds a PRESCALE parameter: the count only advances on
// every PRESCALE-th enabled cycle.
module updown_counter_multimode #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
`ifdef COUNTER_PRESCALE_EN
   parameter int unsigned PRESCALE  = 4,
`endif
   parameter int unsigned STEP_W    = 4
) (
   input logic                         clock,
   input logic                         reset,
   updown_counter_multimode_if.slave   ctr_if
);

   // One extra bit so sums and clamps never truncate silently.
   localparam int unsigned XW = WIDTH + 1;
   localparam logic [XW-1:0] MaxX = XW'(MAX_COUNT);

   typedef enum logic [1:0] {
      ModeWrap     = 2'b00,
      ModeSat      = 2'b01,
      ModeOneShot  = 2'b10,
      ModePingPong = 2'b11
   } mode_e;

   typedef enum logic {StRun, StDone} state_e;

   mode_e            mode;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             dir_q, dir_d;

   logic [XW-1:0]    cnt_x, stp_raw, stp_x, sum_x, diff_x, lv_x;
   logic             d;
   logic             advance;
   logic             fire;

`ifdef COUNTER_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;
`endif

   assign mode = mode_e'(ctr_if.mode);

   // Widened operands, clamped step/load value and effective direction.
   always_comb begin
      cnt_x   = XW'(count_q);
      stp_raw = XW'(ctr_if.step);
      stp_x   = (stp_raw > MaxX) ? MaxX : stp_raw;
      sum_x   = cnt_x + stp_x;
      diff_x  = cnt_x - stp_x;
      lv_x    = (XW'(ctr_if.load_value) > MaxX) ? MaxX : XW'(ctr_if.load_value);
      d       = (mode == ModePingPong) ? dir_q : ctr_if.up_down;
      // A finished one-shot ignores enable until the mode changes, a load or a reset.
      advance = ctr_if.enable && !((state_q == StDone) && (mode == ModeOneShot));
`ifdef COUNTER_PRESCALE_EN
      fire    = advance && (pre_q == PW'(PRESCALE - 1));
`else
      fire    = advance;
`endif
   end

   // Next-state: load beats enable; only firing cycles touch count, dir and tc.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      dir_d   = dir_q;
      state_d = state_q;
`ifdef COUNTER_PRESCALE_EN
      pre_d   = pre_q;
`endif
      if (ctr_if.load) begin
         count_d = WIDTH'(lv_x);
         dir_d   = ctr_if.up_down;
         state_d = StRun;
`ifdef COUNTER_PRESCALE_EN
         pre_d   = '0;
`endif
      end else if (advance) begin
         if (mode != ModeOneShot) begin
            state_d = StRun;
         end
`ifdef COUNTER_PRESCALE_EN
         pre_d = fire ? '0 : pre_q + PW'(1);
`endif
         if (fire) begin
            dir_d = d;
            unique case (mode)
               ModeWrap: begin
                  if (d) begin
                     if (sum_x > MaxX) begin
                        count_d = WIDTH'(sum_x - (MaxX + XW'(1)));
                        tc_d    = 1'b1;
                     end else begin
                        count_d = WIDTH'(sum_x);
                     end
                  end else begin
                     if (cnt_x < stp_x) begin
                        count_d = WIDTH'(cnt_x + (MaxX - stp_x) + XW'(1));
                        tc_d    = 1'b1;
                     end else begin
                        count_d = WIDTH'(diff_x);
                     end
                  end
               end
               ModeSat, ModeOneShot: begin
                  // Only the update that moves onto the bound pulses tc.
                  if (d) begin
                     if (cnt_x != MaxX && sum_x >= MaxX) begin
                        count_d = WIDTH'(MaxX);
                        tc_d    = 1'b1;
                     end else if (cnt_x != MaxX) begin
                        count_d = WIDTH'(sum_x);
                     end
                  end else begin
                     if (cnt_x != '0 && cnt_x <= stp_x) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                     end else if (cnt_x != '0) begin
                        count_d = WIDTH'(diff_x);
                     end
                  end
                  if (tc_d && mode == ModeOneShot) begin
                     state_d = StDone;
                  end
               end
               ModePingPong: begin
                  // A zero step holds the count so it must not bounce.
                  if (stp_x != '0) begin
                     if (d) begin
                        if (sum_x >= MaxX) begin
                           count_d = WIDTH'(MaxX);
                           dir_d   = 1'b0;
                           tc_d    = 1'b1;
                        end else begin
                           count_d = WIDTH'(sum_x);
                        end
                     end else begin
                        if (cnt_x <= stp_x) begin
                           count_d = '0;
                           dir_d   = 1'b1;
                           tc_d    = 1'b1;
                        end else begin
                           count_d = WIDTH'(diff_x);
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State registers with synchronous reset; reset value follows up_down.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= ctr_if.up_down ? '0 : WIDTH'(MAX_COUNT);
         tc_q    <= 1'b0;
         dir_q   <= ctr_if.up_down;
         state_q <= StRun;
`ifdef COUNTER_PRESCALE_EN
         pre_q   <= '0;
`endif
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         dir_q   <= dir_d;
         state_q <= state_d;
`ifdef COUNTER_PRESCALE_EN
         pre_q   <= pre_d;
`endif
      end
   end

   assign ctr_if.count = count_q;
   assign ctr_if.tc    = tc_q;
   assign ctr_if.dir   = dir_q;
   assign ctr_if.done  = (state_q == StDone);

endmodule

// File: tb/tb_updown_counter_multimode.sv
// Bench for updown_counter_multimode: directed vector table plus randomized run against an
// arithmetic reference model.
module tb_updown_counter_multimode;
   localparam int unsigned W  = 4;
   localparam int unsigned M  = 9;
   localparam int unsigned SW = 4;
`ifdef COUNTER_PRESCALE_EN
   localparam int unsigned PS = 3;
`else
   localparam int unsigned PS = 1;
`endif

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   updown_counter_multimode_if #(.WIDTH(W), .STEP_W(SW)) cif ();

   updown_counter_multimode #(
      .WIDTH     (W),
      .MAX_COUNT (M),
`ifdef COUNTER_PRESCALE_EN
      .PRESCALE  (PS),
`endif
      .STEP_W    (SW)
   ) u_dut (
      .clock  (clock),
      .reset  (reset),
      .ctr_if (cif.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit rst, en, ud, ld;
      int lv, st, md;
      int cnt;
      bit tc, dir, done;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   int m_cnt, m_pre;
   bit m_dir, m_done, m_tc;

   function automatic void add(bit rst, bit en, bit ud, bit ld, int lv, int st, int md,
                               int cnt, bit tc, bit dir, bit done);
      vec_t v;
      v.rst = rst; v.en = en; v.ud = ud; v.ld = ld; v.lv = lv; v.st = st; v.md = md;
      v.cnt = cnt; v.tc = tc; v.dir = dir; v.done = done;
      vecs.push_back(v);
   endfunction

   task automatic drive(bit rst, bit en, bit ud, bit ld, int lv, int st, int md);
      reset             = rst;
      cif.enable        = en;
      cif.up_down       = ud;
      cif.load          = ld;
      cif.load_value    = W'(lv);
      cif.step          = SW'(st);
      cif.mode          = 2'(md);
      @(posedge clock);
      #1;
   endtask

   task automatic check(string name, int idx, int cnt, bit tc, bit dir, bit done);
      logic [W-1:0] ec;
      ec = W'(cnt);
      checks += 4;
      if (cif.count !== ec) begin
         errors++;
         $display("FAIL %s[%0d] count got %0d want %0d", name, idx, cif.count, ec);
      end
      if (cif.tc !== tc) begin
         errors++;
         $display("FAIL %s[%0d] tc got %b want %b", name, idx, cif.tc, tc);
      end
      if (cif.dir !== dir) begin
         errors++;
         $display("FAIL %s[%0d] dir got %b want %b", name, idx, cif.dir, dir);
      end
      if (cif.done !== done) begin
         errors++;
         $display("FAIL %s[%0d] done got %b want %b", name, idx, cif.done, done);
      end
   endtask

   // Behavioural model written from the counting rules with plain integer arithmetic.
   task automatic model(bit r, bit en, bit ud, bit ld, int lv, int st, int md);
      int s, tgt, nv;
      bit d;
      m_tc = 0;
      if (r) begin
         m_cnt = ud ? 0 : M; m_dir = ud; m_done = 0; m_pre = 0;
      end else if (ld) begin
         m_cnt = (lv > M) ? M : lv; m_dir = ud; m_done = 0; m_pre = 0;
      end else if (en && !(m_done && md == 2)) begin
         m_done = 0;
         if (m_pre < PS - 1) begin
            m_pre++;
         end else begin
            m_pre = 0;
            s = (st > M) ? M : st;
            d = (md == 3) ? m_dir : ud;
            m_dir = d;
            case (md)
               0: begin
                  if (d) begin
                     m_tc  = (m_cnt + s) > M;
                     m_cnt = (m_cnt + s) % (M + 1);
                  end else begin
                     m_tc  = m_cnt < s;
                     m_cnt = (m_cnt - s + M + 1) % (M + 1);
                  end
               end
               1, 2: begin
                  tgt = d ? M : 0;
                  nv  = d ? ((m_cnt + s > M) ? M : m_cnt + s) : ((m_cnt < s) ? 0 : m_cnt - s);
                  if (m_cnt != tgt && nv == tgt) begin
                     m_tc = 1;
                     if (md == 2) m_done = 1;
                  end
                  m_cnt = nv;
               end
               default: begin
                  if (s > 0) begin
                     if (d) begin
                        if (m_cnt + s >= M) begin m_cnt = M; m_dir = 0; m_tc = 1; end
                        else m_cnt = m_cnt + s;
                     end else begin
                        if (m_cnt <= s) begin m_cnt = 0; m_dir = 1; m_tc = 1; end
                        else m_cnt = m_cnt - s;
                     end
                  end
               end
            endcase
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      cif.enable = 0; cif.up_down = 1; cif.load = 0; cif.load_value = '0;
      cif.step = '0; cif.mode = '0;

`ifndef COUNTER_PRESCALE_EN
      //   rst en ud ld lv st md   cnt tc dir done
      // Wrap up, step 3
      add(1, 0, 1, 0, 0, 3, 0,    0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 3, 0,    3, 0, 1, 0);
      add(0, 1, 1, 0, 0, 3, 0,    6, 0, 1, 0);
      add(0, 1, 1, 0, 0, 3, 0,    9, 0, 1, 0);
      add(0, 1, 1, 0, 0, 3, 0,    2, 1, 1, 0);
      // Saturate down, step 4
      add(0, 0, 0, 1, 6, 4, 1,    6, 0, 0, 0);
      add(0, 1, 0, 0, 0, 4, 1,    2, 0, 0, 0);
      add(0, 1, 0, 0, 0, 4, 1,    0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 4, 1,    0, 0, 0, 0);
      // One-shot up, step 2
      add(0, 0, 1, 1, 5, 2, 2,    5, 0, 1, 0);
      add(0, 1, 1, 0, 0, 2, 2,    7, 0, 1, 0);
      add(0, 1, 1, 0, 0, 2, 2,    9, 1, 1, 1);
      add(0, 1, 1, 0, 0, 2, 2,    9, 0, 1, 1);
      add(0, 1, 1, 0, 0, 2, 2,    9, 0, 1, 1);
      add(0, 0, 1, 1, 0, 2, 2,    0, 0, 1, 0);
      add(0, 1, 1, 0, 0, 2, 2,    2, 0, 1, 0);
      add(0, 1, 1, 0, 0, 15, 2,   9, 1, 1, 1);
      add(0, 1, 1, 0, 0, 2, 0,    1, 1, 1, 0);   // leaving one-shot from DONE
      // Ping-pong, step 4
      add(1, 0, 1, 0, 0, 4, 3,    0, 0, 1, 0);
      add(0, 1, 0, 0, 0, 4, 3,    4, 0, 1, 0);
      add(0, 1, 0, 0, 0, 4, 3,    8, 0, 1, 0);
      add(0, 1, 0, 0, 0, 4, 3,    9, 1, 0, 0);
      add(0, 1, 1, 0, 0, 4, 3,    5, 0, 0, 0);
      add(0, 1, 1, 0, 0, 4, 3,    1, 0, 0, 0);
      add(0, 1, 1, 0, 0, 4, 3,    0, 1, 1, 0);
      add(0, 1, 1, 0, 0, 0, 3,    0, 0, 1, 0);   // zero step holds
      // Load beats enable, clamped; idle hold; reset mid-count
      add(0, 1, 1, 1, 12, 3, 0,   9, 0, 1, 0);
      add(0, 1, 1, 0, 0, 3, 0,    2, 1, 1, 0);
      add(0, 0, 0, 0, 0, 3, 0,    2, 0, 1, 0);
      add(1, 1, 0, 0, 0, 3, 0,    9, 0, 0, 0);
      add(0, 1, 0, 0, 0, 15, 0,   0, 0, 0, 0);   // step clamps to 9
      add(0, 1, 0, 0, 0, 15, 0,   1, 1, 0, 0);
`else
      add(1, 0, 1, 0, 0, 1, 0,    0, 0, 1, 0);
      for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 1, 0, i / 3, 0, 1, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].lv, vecs[i].st,
               vecs[i].md);
         check("vec", i, vecs[i].cnt, vecs[i].tc, vecs[i].dir, vecs[i].done);
      end

      // Randomized run against the model
      model(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      check("rnd_rst", 0, m_cnt, m_tc, m_dir, m_done);
      for (int i = 0; i < 600; i++) begin
         bit r, en, ud, ld;
         int lv, st, md;
         r  = ($urandom_range(0, 59) == 0);
         ld = ($urandom_range(0, 11) == 0);
         en = ($urandom_range(0, 9) < 7);
         ud = $urandom_range(0, 1);
         lv = $urandom_range(0, 15);
         st = $urandom_range(0, 15);
         md = (i % 40 < 35) ? (i / 40) % 4 : $urandom_range(0, 3);
         model(r, en, ud, ld, lv, st, md);
         drive(r, en, ud, ld, lv, st, md);
         check("rnd", i, m_cnt, m_tc, m_dir, m_done);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
